// File: rtl/axi4_slave_write_responder.sv
// AXI4 slave write responder: one burst at a time into a word memory (FIXED/INCR/WRAP, byte strobes),
// B response with SLVERR on bad burst/size/length, out-of-range address or wlast mismatch.
module axi4_slave_write_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [ID_WIDTH-1:0]           awid,
    input  logic [ADDR_WIDTH-1:0]         awaddr,
    input  logic [7:0]                    awlen,
    input  logic [2:0]                    awsize,
    input  logic [1:0]                    awburst,
    input  logic                          awvalid,
    output logic                          awready,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic [DATA_WIDTH/8-1:0]       wstrb,
    input  logic                          wlast,
    input  logic                          wvalid,
    output logic                          wready,
    output logic [ID_WIDTH-1:0]           bid,
    output logic [1:0]                    bresp,
    output logic                          bvalid,
    input  logic                          bready,
    input  logic [$clog2(MEM_DEPTH)-1:0]  dbg_addr,
    output logic [DATA_WIDTH-1:0]         dbg_rdata
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LOG2B = $clog2(BYTES);
    localparam int IW    = $clog2(MEM_DEPTH);
    localparam longint unsigned MEM_BYTES = longint'(MEM_DEPTH) * BYTES;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

    state_t                r_state;
    logic                  r_awready, r_wready, r_bvalid;
    logic [1:0]            r_bresp;
    logic [ID_WIDTH-1:0]   r_bid, r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len, r_beat;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic                  w_aw_hs, w_w_hs, w_last_beat, w_oor, w_wr_en, w_cap_err, w_beat_err;
    logic [IW-1:0]         w_idx;
    logic [ADDR_WIDTH-1:0] w_inc, w_wmask, w_next_addr;

    assign w_aw_hs     = awvalid && r_awready;
    assign w_w_hs      = wvalid && r_wready;
    assign w_last_beat = (r_beat == r_len);
    assign w_oor       = (64'(r_addr) >= MEM_BYTES);
    assign w_wr_en     = w_w_hs && !r_err && !w_oor && !areset;
    assign w_idx       = r_addr[LOG2B +: IW];
    assign w_inc       = ADDR_WIDTH'(1) << r_size;
    assign w_wmask     = ((ADDR_WIDTH'(r_len) + ADDR_WIDTH'(1)) << r_size) - ADDR_WIDTH'(1);
    assign w_cap_err   = (awburst == 2'b11) || (awsize > 3'(LOG2B)) ||
                         ((awburst == 2'b10) && !(awlen inside {8'd1, 8'd3, 8'd7, 8'd15}));
    assign w_beat_err  = w_oor || (wlast != w_last_beat);

    always_comb begin
        w_next_addr = r_addr + w_inc;
        case (r_burst)
            2'b00:   w_next_addr = r_addr;
            2'b10:   w_next_addr = (r_addr & ~w_wmask) | ((r_addr + w_inc) & w_wmask);
            default: w_next_addr = r_addr + w_inc;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state   <= S_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_bid     <= '0;
            r_beat    <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_awready <= 1'b1;
                    if (w_aw_hs) begin
                        r_id      <= awid;
                        r_addr    <= awaddr;
                        r_len     <= awlen;
                        r_size    <= awsize;
                        r_burst   <= awburst;
                        r_beat    <= '0;
                        r_err     <= w_cap_err;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_w_hs) begin
                        r_err  <= r_err || w_beat_err;
                        r_addr <= w_next_addr;
                        r_beat <= r_beat + 8'd1;
                        // The burst length is authoritative; wlast only contributes to the error flag.
                        if (w_last_beat) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_err || w_beat_err) ? 2'b10 : 2'b00;
                            r_bid    <= r_id;
                            r_state  <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Memory has no reset so contents survive an aborted burst.
    always_ff @(posedge aclk) begin
        if (w_wr_en) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wstrb[i]) r_mem[w_idx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign awready   = r_awready;
    assign wready    = r_wready;
    assign bvalid    = r_bvalid;
    assign bresp     = r_bresp;
    assign bid       = r_bid;
    assign dbg_rdata = r_mem[dbg_addr];
endmodule

// File: tb/tb_axi4_slave_write_responder.sv
// Bench for axi4_slave_write_responder: vector table of bursts, B-response scoreboard, reset/backpressure sequences.
module tb_axi4_slave_write_responder;
    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [7:0]  dbg_addr = '0;
    logic [31:0] dbg_rdata;

    axi4_slave_write_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MEM_DEPTH(256)) dut (
        .aclk(aclk), .areset(areset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [3:0]       id;
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [3:0][31:0] data;
        logic [3:0]       strb;
        logic [1:0]       lastb;
        logic [1:0]       resp;
        logic [2:0]       nchk;
        logic [3:0][7:0]  cidx;
        logic [3:0][31:0] cval;
    } vec_t;

    typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;

    int    checks = 0;
    int    failures = 0;
    bexp_t sb[$];
    vec_t  vt[12];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=handshake", name);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        while (!awready && n < 50) begin tick(); n++; end
        if (!awready) begin timeout("aw_wait"); awvalid = 1'b0; return; end
        tick();
        awvalid = 1'b0;
        chk("wready_lat", {63'd0, wready}, 64'd1);
        chk("awready_drop", {63'd0, awready}, 64'd0);
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        while (!wready && n < 50) begin tick(); n++; end
        if (!wready) timeout("w_wait");
        else tick();
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic wait_b();
        int    n = 0;
        bexp_t e;
        while (!bvalid && n < 50) begin tick(); n++; end
        if (!bvalid) begin timeout("b_wait"); return; end
        if (sb.size() == 0) begin timeout("sb_underflow"); return; end
        e = sb.pop_front();
        chk("bid", {60'd0, bid}, {60'd0, e.id});
        chk("bresp", {62'd0, bresp}, {62'd0, e.resp});
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("bvalid_clear", {63'd0, bvalid}, 64'd0);
        chk("awready_after_b", {63'd0, awready}, 64'd1);
    endtask

    task automatic run_burst(input vec_t v, input int hold);
        bexp_t e;
        e.id = v.id; e.resp = v.resp;
        sb.push_back(e);
        send_aw(v.id, v.addr, v.len, v.size, v.burst);
        for (int b = 0; b <= int'(v.len); b++)
            send_w(v.data[b], v.strb, (2'(b) == v.lastb));
        chk("bvalid_lat", {63'd0, bvalid}, 64'd1);
        chk("wready_drop", {63'd0, wready}, 64'd0);
        for (int h = 0; h < hold; h++) begin
            chk("hold_bvalid", {63'd0, bvalid}, 64'd1);
            chk("hold_bid", {60'd0, bid}, {60'd0, v.id});
            chk("hold_bresp", {62'd0, bresp}, {62'd0, v.resp});
            chk("hold_awready", {63'd0, awready}, 64'd0);
            tick();
        end
        wait_b();
        for (int k = 0; k < int'(v.nchk); k++) begin
            dbg_addr = v.cidx[k];
            #1;
            chk("mem", {32'd0, dbg_rdata}, {32'd0, v.cval[k]});
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // {id, addr, len, size, burst, data[3:0], strb, lastb, resp, nchk, cidx[3:0], cval[3:0]}
        vt[0]  = '{4'd5, 32'h10, 8'd3, 3'd2, 2'b01, {32'h44, 32'h33, 32'h22, 32'h11}, 4'hF, 2'd3, 2'b00,
                   3'd4, {8'h07, 8'h06, 8'h05, 8'h04}, {32'h44, 32'h33, 32'h22, 32'h11}};
        vt[1]  = '{4'd1, 32'h38, 8'd3, 3'd2, 2'b10, {32'h0D0D0D0D, 32'h0C0C0C0C, 32'h0B0B0B0B, 32'h0A0A0A0A},
                   4'hF, 2'd3, 2'b00, 3'd4, {8'h0D, 8'h0C, 8'h0F, 8'h0E},
                   {32'h0D0D0D0D, 32'h0C0C0C0C, 32'h0B0B0B0B, 32'h0A0A0A0A}};
        vt[2]  = '{4'd2, 32'h0, 8'd0, 3'd2, 2'b00, {32'h0, 32'h0, 32'h0, 32'hAABBCCDD}, 4'hF, 2'd0, 2'b00,
                   3'd1, {8'h0, 8'h0, 8'h0, 8'h0}, {32'h0, 32'h0, 32'h0, 32'hAABBCCDD}};
        vt[3]  = '{4'd3, 32'h0, 8'd0, 3'd2, 2'b00, {32'h0, 32'h0, 32'h0, 32'h11223344}, 4'h5, 2'd0, 2'b00,
                   3'd1, {8'h0, 8'h0, 8'h0, 8'h0}, {32'h0, 32'h0, 32'h0, 32'hAA22CC44}};
        vt[4]  = '{4'd4, 32'h400, 8'd0, 3'd2, 2'b01, {32'h0, 32'h0, 32'h0, 32'hDEADBEEF}, 4'hF, 2'd0, 2'b10,
                   3'd1, {8'h0, 8'h0, 8'h0, 8'h0}, {32'h0, 32'h0, 32'h0, 32'hAA22CC44}};
        vt[5]  = '{4'd6, 32'h40, 8'd3, 3'd2, 2'b01, {32'h40404040, 32'h30303030, 32'h20202020, 32'h10101010},
                   4'hF, 2'd1, 2'b10, 3'd1, {8'h0, 8'h0, 8'h0, 8'h10}, {32'h0, 32'h0, 32'h0, 32'h10101010}};
        vt[6]  = '{4'd7, 32'h80, 8'd0, 3'd2, 2'b01, {32'h0, 32'h0, 32'h0, 32'h5A5A5A5A}, 4'hF, 2'd0, 2'b00,
                   3'd1, {8'h0, 8'h0, 8'h0, 8'h20}, {32'h0, 32'h0, 32'h0, 32'h5A5A5A5A}};
        vt[7]  = '{4'd8, 32'h80, 8'd0, 3'd2, 2'b11, {32'h0, 32'h0, 32'h0, 32'hFFFFFFFF}, 4'hF, 2'd0, 2'b10,
                   3'd1, {8'h0, 8'h0, 8'h0, 8'h20}, {32'h0, 32'h0, 32'h0, 32'h5A5A5A5A}};
        vt[8]  = '{4'd9, 32'h90, 8'd2, 3'd2, 2'b10, {32'h0, 32'h3, 32'h2, 32'h1}, 4'hF, 2'd2, 2'b10,
                   3'd0, {8'h0, 8'h0, 8'h0, 8'h0}, {32'h0, 32'h0, 32'h0, 32'h0}};
        vt[9]  = '{4'd10, 32'hA0, 8'd0, 3'd3, 2'b01, {32'h0, 32'h0, 32'h0, 32'h1}, 4'hF, 2'd0, 2'b10,
                   3'd0, {8'h0, 8'h0, 8'h0, 8'h0}, {32'h0, 32'h0, 32'h0, 32'h0}};
        vt[10] = '{4'd11, 32'hC0, 8'd1, 3'd2, 2'b00, {32'h0, 32'h0, 32'h22222222, 32'h11111111}, 4'hF, 2'd1,
                   2'b00, 3'd1, {8'h0, 8'h0, 8'h0, 8'h30}, {32'h0, 32'h0, 32'h0, 32'h22222222}};
        vt[11] = '{4'd12, 32'hD0, 8'd3, 3'd0, 2'b01, {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0},
                   4'hF, 2'd3, 2'b00, 3'd1, {8'h0, 8'h0, 8'h0, 8'h34}, {32'h0, 32'h0, 32'h0, 32'hD3D3D3D3}};

        // Reset state
        tick(); tick(); tick();
        chk("rst_awready", {63'd0, awready}, 64'd0);
        chk("rst_wready", {63'd0, wready}, 64'd0);
        chk("rst_bvalid", {63'd0, bvalid}, 64'd0);
        chk("rst_bresp", {62'd0, bresp}, 64'd0);
        chk("rst_bid", {60'd0, bid}, 64'd0);
        areset = 1'b0;
        tick();
        chk("rel_awready", {63'd0, awready}, 64'd1);

        // Reset in the middle of a burst: two beats land, no B response
        send_aw(4'd3, 32'h60, 8'd3, 3'd2, 2'b01);
        send_w(32'h77, 4'hF, 1'b0);
        send_w(32'h88, 4'hF, 1'b0);
        areset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("midrst_awready", {63'd0, awready}, 64'd0);
            chk("midrst_wready", {63'd0, wready}, 64'd0);
            chk("midrst_bvalid", {63'd0, bvalid}, 64'd0);
        end
        areset = 1'b0;
        tick();
        chk("midrst_rel_awready", {63'd0, awready}, 64'd1);
        chk("midrst_no_b", {63'd0, bvalid}, 64'd0);
        dbg_addr = 8'h18; #1;
        chk("midrst_mem0", {32'd0, dbg_rdata}, 64'h77);
        dbg_addr = 8'h19; #1;
        chk("midrst_mem1", {32'd0, dbg_rdata}, 64'h88);

        // Table of back-to-back bursts; the first one also sees 5 cycles of B backpressure
        for (int i = 0; i < 12; i++) run_burst(vt[i], (i == 0) ? 5 : 0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
